// File: rtl/vote_tally_result.sv
// Vote tally: extends the 3-bit wrapping vote counters into saturating totals and decides the poll result.
// Optional define MARGIN_OUT_EN adds the |total1-total2| margin output.
module vote_tally_result #(
  parameter int unsigned TOT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       ctr1,
  input  logic [2:0]       ctr2,
  input  logic [2:0]       ctr3,
  input  logic             open_poll,
  input  logic             close_poll,
  input  logic             res_ready,
  output logic [TOT_W-1:0] total1,
  output logic [TOT_W-1:0] total2,
  output logic [TOT_W-1:0] total3,
  output logic [1:0]       winner,
  output logic             tie,
  output logic             res_valid,
  output logic             poll_open,
  output logic             sat_flag
`ifdef MARGIN_OUT_EN
  ,
  output logic [TOT_W-1:0] margin
`endif
);

  localparam int unsigned SUM_W = TOT_W + 1;
  localparam logic [SUM_W-1:0] SAT_MAX = SUM_W'((1 << TOT_W) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_OPEN   = 3'd1;
  localparam logic [2:0] S_DECIDE = 3'd2;
  localparam logic [2:0] S_RESULT = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic             w_open_ok;

  logic [2:0]       w_ctr      [0:2];
  logic [2:0]       r_prev     [0:2];
  logic [2:0]       w_delta    [0:2];
  logic [SUM_W-1:0] w_sum      [0:2];
  logic             w_hit      [0:2];
  logic [TOT_W-1:0] w_total_nx [0:2];
  logic [TOT_W-1:0] r_total    [0:2];

  logic [1:0]       r_winner;
  logic             r_tie;
  logic             r_res_valid;
  logic             r_poll_open;
  logic             r_sat_flag;
  logic             w_any_hit;

  assign w_ctr[0] = ctr1;
  assign w_ctr[1] = ctr2;
  assign w_ctr[2] = ctr3;

  // open_poll is honoured everywhere except the single DECIDE cycle
  assign w_open_ok = open_poll && (r_state != S_DECIDE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_open_ok) begin
      w_state_nxt = S_OPEN;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_IDLE;
        S_OPEN:   if (close_poll) w_state_nxt = S_DECIDE;
        S_DECIDE: w_state_nxt = S_RESULT;
        S_RESULT: if (r_res_valid && res_ready) w_state_nxt = S_LOCKED;
        S_LOCKED: w_state_nxt = S_LOCKED;
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Modulo-8 delta since last cycle, added with saturation
  always_comb begin
    for (int k = 0; k < 3; k++) begin
      w_delta[k]    = w_ctr[k] - r_prev[k];
      w_sum[k]      = {1'b0, r_total[k]} + SUM_W'(w_delta[k]);
      w_hit[k]      = (w_sum[k] >= SAT_MAX);
      w_total_nx[k] = w_hit[k] ? TOT_W'(SAT_MAX) : w_sum[k][TOT_W-1:0];
    end
  end

  assign w_any_hit = w_hit[0] | w_hit[1] | w_hit[2];

`ifdef MARGIN_OUT_EN
  logic [TOT_W-1:0] r_margin;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        r_prev[k]  <= 3'd0;
        r_total[k] <= '0;
      end
      r_winner    <= 2'd0;
      r_tie       <= 1'b0;
      r_res_valid <= 1'b0;
      r_poll_open <= 1'b0;
      r_sat_flag  <= 1'b0;
`ifdef MARGIN_OUT_EN
      r_margin    <= '0;
`endif
    end else begin
      for (int k = 0; k < 3; k++) r_prev[k] <= w_ctr[k];
      r_poll_open <= (w_state_nxt == S_OPEN);
      r_res_valid <= (w_state_nxt == S_RESULT);
      if (w_open_ok) begin
        for (int k = 0; k < 3; k++) r_total[k] <= '0;
        r_sat_flag <= 1'b0;
        r_winner   <= 2'd0;
        r_tie      <= 1'b0;
`ifdef MARGIN_OUT_EN
        r_margin   <= '0;
`endif
      end else if (r_state == S_OPEN) begin
        for (int k = 0; k < 3; k++) r_total[k] <= w_total_nx[k];
        if (w_any_hit) r_sat_flag <= 1'b1;
      end else if (r_state == S_DECIDE) begin
        if (r_total[0] > r_total[1])      r_winner <= 2'd1;
        else if (r_total[1] > r_total[0]) r_winner <= 2'd2;
        else                              r_winner <= 2'd0;
        r_tie <= (r_total[0] == r_total[1]);
`ifdef MARGIN_OUT_EN
        r_margin <= (r_total[0] > r_total[1]) ? (r_total[0] - r_total[1])
                                              : (r_total[1] - r_total[0]);
`endif
      end
    end
  end

  assign total1    = r_total[0];
  assign total2    = r_total[1];
  assign total3    = r_total[2];
  assign winner    = r_winner;
  assign tie       = r_tie;
  assign res_valid = r_res_valid;
  assign poll_open = r_poll_open;
  assign sat_flag  = r_sat_flag;
`ifdef MARGIN_OUT_EN
  assign margin    = r_margin;
`endif

endmodule

// File: tb/tb_vote_tally_result.sv
// Bench for vote_tally_result: two instances (TOT_W=8 and TOT_W=4) against a behavioural poll model.
module tb_vote_tally_result;

  localparam int unsigned W_A = 8;
  localparam int unsigned W_B = 4;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] ctr1, ctr2, ctr3;
  logic open_poll, close_poll, res_ready;

  logic [W_A-1:0] t1a, t2a, t3a;
  logic [W_B-1:0] t1b, t2b, t3b;
  logic [1:0] wa, wb;
  logic tie_a, tie_b, rv_a, rv_b, po_a, po_b, sat_a, sat_b;
`ifdef MARGIN_OUT_EN
  logic [W_A-1:0] mar_a;
  logic [W_B-1:0] mar_b;
`endif

  always #5 clk = ~clk;

  vote_tally_result #(.TOT_W(W_A)) u_dut_a (
    .clk(clk), .rst(rst), .ctr1(ctr1), .ctr2(ctr2), .ctr3(ctr3),
    .open_poll(open_poll), .close_poll(close_poll), .res_ready(res_ready),
    .total1(t1a), .total2(t2a), .total3(t3a), .winner(wa), .tie(tie_a),
    .res_valid(rv_a), .poll_open(po_a), .sat_flag(sat_a)
`ifdef MARGIN_OUT_EN
    , .margin(mar_a)
`endif
  );

  vote_tally_result #(.TOT_W(W_B)) u_dut_b (
    .clk(clk), .rst(rst), .ctr1(ctr1), .ctr2(ctr2), .ctr3(ctr3),
    .open_poll(open_poll), .close_poll(close_poll), .res_ready(res_ready),
    .total1(t1b), .total2(t2b), .total3(t3b), .winner(wb), .tie(tie_b),
    .res_valid(rv_b), .poll_open(po_b), .sat_flag(sat_b)
`ifdef MARGIN_OUT_EN
    , .margin(mar_b)
`endif
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: index 0 = wide instance, 1 = narrow instance
  int mt[2][3];
  int mmax[2];
  bit msat[2];
  int mwin[2];
  bit mtie[2];
  int mmar[2];
  bit m_acc, m_dec, m_val;
  int prev[3];

  task automatic check(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    mmax[0] = (1 << W_A) - 1;
    mmax[1] = (1 << W_B) - 1;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) mt[i][k] = 0;
      msat[i] = 0; mwin[i] = 0; mtie[i] = 0; mmar[i] = 0;
    end
    for (int k = 0; k < 3; k++) prev[k] = 0;
    m_acc = 0; m_dec = 0; m_val = 0;
  endtask

  task automatic model_clock();
    int cur[3];
    int d[3];
    int s;
    cur[0] = int'(ctr1); cur[1] = int'(ctr2); cur[2] = int'(ctr3);
    for (int k = 0; k < 3; k++) begin
      d[k] = (cur[k] - prev[k] + 8) % 8;
      prev[k] = cur[k];
    end
    if (open_poll && !m_dec) begin
      for (int i = 0; i < 2; i++) begin
        for (int k = 0; k < 3; k++) mt[i][k] = 0;
        msat[i] = 0; mwin[i] = 0; mtie[i] = 0; mmar[i] = 0;
      end
      m_acc = 1; m_val = 0;
    end else if (m_acc) begin
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 3; k++) begin
          s = mt[i][k] + d[k];
          if (s >= mmax[i]) begin s = mmax[i]; msat[i] = 1; end
          mt[i][k] = s;
        end
      if (close_poll) begin m_acc = 0; m_dec = 1; end
    end else if (m_dec) begin
      m_dec = 0; m_val = 1;
      for (int i = 0; i < 2; i++) begin
        mwin[i] = (mt[i][0] > mt[i][1]) ? 1 : (mt[i][1] > mt[i][0]) ? 2 : 0;
        mtie[i] = (mt[i][0] == mt[i][1]);
        mmar[i] = (mt[i][0] > mt[i][1]) ? mt[i][0] - mt[i][1] : mt[i][1] - mt[i][0];
      end
    end else if (m_val && res_ready) begin
      m_val = 0;
    end
  endtask

  task automatic check_all();
    check("a_total1", int'(t1a), mt[0][0]);
    check("a_total2", int'(t2a), mt[0][1]);
    check("a_total3", int'(t3a), mt[0][2]);
    check("a_winner", int'(wa), mwin[0]);
    check("a_tie", int'(tie_a), int'(mtie[0]));
    check("a_sat", int'(sat_a), int'(msat[0]));
    check("a_res_valid", int'(rv_a), int'(m_val));
    check("a_poll_open", int'(po_a), int'(m_acc));
    check("b_total1", int'(t1b), mt[1][0]);
    check("b_total2", int'(t2b), mt[1][1]);
    check("b_total3", int'(t3b), mt[1][2]);
    check("b_winner", int'(wb), mwin[1]);
    check("b_tie", int'(tie_b), int'(mtie[1]));
    check("b_sat", int'(sat_b), int'(msat[1]));
    check("b_res_valid", int'(rv_b), int'(m_val));
    check("b_poll_open", int'(po_b), int'(m_acc));
`ifdef MARGIN_OUT_EN
    check("a_margin", int'(mar_a), mmar[0]);
    check("b_margin", int'(mar_b), mmar[1]);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic bump(input int k1, input int k2, input int k3);
    ctr1 = ctr1 + 3'(k1);
    ctr2 = ctr2 + 3'(k2);
    ctr3 = ctr3 + 3'(k3);
    step();
  endtask

  task automatic pulse_open();
    open_poll = 1'b1;
    step();
    open_poll = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    ctr1 = 3'd0; ctr2 = 3'd0; ctr3 = 3'd0;
    open_poll = 1'b0; close_poll = 1'b0; res_ready = 1'b0;
    model_reset();
    #12;
    check_all();
    check("rst_poll_open", int'(po_a), 0);
    @(negedge clk);
    rst = 1'b0;

    // Basic counting and counter wrap
    pulse_open();
    repeat (3) bump(1, 0, 0);
    check("dir_t1_three", int'(t1a), 3);
    check("dir_t2_zero", int'(t2a), 0);
    check("dir_poll_open", int'(po_a), 1);
    pulse_open();
    repeat (10) bump(0, 1, 0);
    check("dir_t2_wrap", int'(t2a), 10);

    // 5/5/2 tie, close with downstream stalled
    pulse_open();
    repeat (5) bump(1, 1, 0);
    repeat (2) bump(0, 0, 1);
    res_ready = 1'b0;
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    check("lat_n1_valid", int'(rv_a), 0);
    step();
    check("lat_n2_valid", int'(rv_a), 1);
    check("tie_winner", int'(wa), 0);
    check("tie_flag", int'(tie_a), 1);
    repeat (3) step();
    check("stall_valid", int'(rv_a), 1);
    check("stall_t1", int'(t1a), 5);
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;
    check("accept_valid_low", int'(rv_a), 0);

    // Locked: deltas discarded
    repeat (2) bump(1, 0, 0);
    check("locked_t1", int'(t1a), 5);
    pulse_open();
    check("reopen_t1", int'(t1a), 0);
    check("reopen_poll", int'(po_a), 1);

    // Saturation on the narrow instance
    repeat (20) bump(1, 0, 0);
    check("sat_b_t1", int'(t1b), 15);
    check("sat_b_flag", int'(sat_b), 1);
    check("sat_a_t1", int'(t1a), 20);
    check("sat_a_flag", int'(sat_a), 0);
    pulse_open();
    check("sat_b_clear", int'(sat_b), 0);

    // open + close together: open wins
    repeat (3) bump(1, 2, 1);
    open_poll = 1'b1; close_poll = 1'b1;
    step();
    open_poll = 1'b0; close_poll = 1'b0;
    check("oc_t1", int'(t1a), 0);
    check("oc_poll", int'(po_a), 1);
    repeat (3) begin
      step();
      check("oc_no_valid", int'(rv_a), 0);
    end

    // Winner and margin, 9/4
    pulse_open();
    repeat (4) bump(1, 1, 0);
    repeat (5) bump(1, 0, 0);
    close_poll = 1'b1;
    step();
    close_poll = 1'b0;
    step();
    check("w1_winner", int'(wa), 1);
    check("w1_tie", int'(tie_a), 0);
`ifdef MARGIN_OUT_EN
    check("w1_margin", int'(mar_a), 5);
`endif
    res_ready = 1'b1;
    step();
    res_ready = 1'b0;

    // Async reset mid-poll
    pulse_open();
    repeat (3) bump(1, 2, 1);
    #2;
    rst = 1'b1;
    ctr1 = 3'd0; ctr2 = 3'd0; ctr3 = 3'd0;
    model_reset();
    #1;
    check_all();
    check("arst_t2", int'(t2a), 0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Randomized traffic
    repeat (3000) begin
      open_poll  = ($urandom_range(0, 39) == 0);
      close_poll = ($urandom_range(0, 11) == 0);
      res_ready  = ($urandom_range(0, 2) != 0);
      ctr1 = ctr1 + 3'($urandom_range(0, 2));
      ctr2 = ctr2 + 3'($urandom_range(0, 2));
      ctr3 = ctr3 + 3'($urandom_range(0, 1));
      if ($urandom_range(0, 19) == 0) ctr1 = ctr1 + 3'($urandom_range(0, 7));
      if ($urandom_range(0, 19) == 0) ctr2 = ctr2 + 3'($urandom_range(0, 7));
      step();
    end
    open_poll = 1'b0; close_poll = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
